// File: rtl/cmult_pipe.sv
// Three-stage pipelined fixed-point complex multiplier with optional conj(b).
// Define CMULT_PIPE_SAT_EN to saturate results and drive ovf; otherwise wrap.
module cmult_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic             conj_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;

  localparam logic signed [SW-1:0] RND =
    {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);

  logic en;

  logic                    v1;
  logic signed [WIDTH-1:0] s1_ar;
  logic signed [WIDTH-1:0] s1_ai;
  logic signed [WIDTH-1:0] s1_br;
  logic signed [WIDTH-1:0] s1_bi;
  logic                    s1_cj;

  logic                 v2;
  logic signed [PW-1:0] s2_rr;
  logic signed [PW-1:0] s2_ii;
  logic signed [PW-1:0] s2_ri;
  logic signed [PW-1:0] s2_ir;
  logic                 s2_cj;

  logic signed [PW-1:0] xar, xai, xbr, xbi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  logic signed [SW-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [SW-1:0] re_sh, im_sh;

  logic [WIDTH-1:0] re_n;
  logic [WIDTH-1:0] im_n;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  assign xar = PW'(s1_ar);
  assign xai = PW'(s1_ai);
  assign xbr = PW'(s1_br);
  assign xbi = PW'(s1_bi);

  assign p_rr = xar * xbr;
  assign p_ii = xai * xbi;
  assign p_ri = xar * xbi;
  assign p_ir = xai * xbr;

  assign e_rr = SW'(s2_rr);
  assign e_ii = SW'(s2_ii);
  assign e_ri = SW'(s2_ri);
  assign e_ir = SW'(s2_ir);

  // conj(b) flips the sign of every term carrying b_im
  assign re_sum = s2_cj ? e_rr + e_ii : e_rr - e_ii;
  assign im_sum = s2_cj ? e_ir - e_ri : e_ri + e_ir;

  assign re_sh = (re_sum + RND) >>> FRAC;
  assign im_sh = (im_sum + RND) >>> FRAC;

`ifdef CMULT_PIPE_SAT_EN
  localparam logic signed [SW-1:0] MAXV =
    {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic ovf_n;
  logic ovf_q;

  always_comb begin
    re_n  = re_sh[WIDTH-1:0];
    im_n  = im_sh[WIDTH-1:0];
    ovf_n = 1'b0;
    if (re_sh > MAXV) begin
      re_n  = MAXV[WIDTH-1:0];
      ovf_n = 1'b1;
    end else if (re_sh < MINV) begin
      re_n  = MINV[WIDTH-1:0];
      ovf_n = 1'b1;
    end
    if (im_sh > MAXV) begin
      im_n  = MAXV[WIDTH-1:0];
      ovf_n = 1'b1;
    end else if (im_sh < MINV) begin
      im_n  = MINV[WIDTH-1:0];
      ovf_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_n;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_hi;

  assign re_n      = re_sh[WIDTH-1:0];
  assign im_n      = im_sh[WIDTH-1:0];
  assign ovf       = 1'b0;
  assign unused_hi = ^{re_sh[SW-1:WIDTH],
                       im_sh[SW-1:WIDTH]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_ar     <= '0;
      s1_ai     <= '0;
      s1_br     <= '0;
      s1_bi     <= '0;
      s1_cj     <= 1'b0;
      v2        <= 1'b0;
      s2_rr     <= '0;
      s2_ii     <= '0;
      s2_ri     <= '0;
      s2_ir     <= '0;
      s2_cj     <= 1'b0;
      out_valid <= 1'b0;
      m_re      <= '0;
      m_im      <= '0;
    end else if (en) begin
      v1        <= in_valid;
      s1_ar     <= a_re;
      s1_ai     <= a_im;
      s1_br     <= b_re;
      s1_bi     <= b_im;
      s1_cj     <= conj_b;
      v2        <= v1;
      s2_rr     <= p_rr;
      s2_ii     <= p_ii;
      s2_ri     <= p_ri;
      s2_ir     <= p_ir;
      s2_cj     <= s1_cj;
      out_valid <= v2;
      m_re      <= re_n;
      m_im      <= im_n;
    end
  end

endmodule

// File: tb/tb_cmult_pipe.sv
// Directed and randomised checks for cmult_pipe at WIDTH=16, FRAC=15.
// Expected values follow CMULT_PIPE_SAT_EN when it is defined.
module tb_cmult_pipe;

  typedef struct packed {
    logic [15:0] ar;
    logic [15:0] ai;
    logic [15:0] br;
    logic [15:0] bi;
    logic        cj;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_re = '0;
  logic [15:0] a_im = '0;
  logic [15:0] b_re = '0;
  logic [15:0] b_im = '0;
  logic        conj_b = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] m_re;
  logic [15:0] m_im;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cmult_pipe #(.WIDTH(16), .FRAC(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .conj_b   (conj_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .ovf      (ovf)
  );

  // golden model in plain integer arithmetic: {ovf, re, im}
  function automatic logic [32:0] model(op_t o);
    longint ar, ai, br, bi, re, im;
    logic   ov;
    ar = longint'($signed(o.ar));
    ai = longint'($signed(o.ai));
    br = longint'($signed(o.br));
    bi = longint'($signed(o.bi));
    if (o.cj) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    re = (re + 64'sd16384) >>> 15;
    im = (im + 64'sd16384) >>> 15;
    ov = 1'b0;
`ifdef CMULT_PIPE_SAT_EN
    if (re > 32767) begin
      re = 32767; ov = 1'b1;
    end else if (re < -32768) begin
      re = -32768; ov = 1'b1;
    end
    if (im > 32767) begin
      im = 32767; ov = 1'b1;
    end else if (im < -32768) begin
      im = -32768; ov = 1'b1;
    end
`endif
    return {ov, re[15:0], im[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'h7FFF;
    return 16'($urandom);
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.ar = pick();
    o.ai = pick();
    o.br = pick();
    o.bi = pick();
    o.cj = 1'($urandom_range(0, 1));
    return o;
  endfunction

  task automatic drive(op_t o, logic v);
    in_valid = v;
    a_re     = o.ar;
    a_im     = o.ai;
    b_re     = o.br;
    b_im     = o.bi;
    conj_b   = o.cj;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, m_re, m_im, ovf} !== 34'b0
        || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got v=%b re=%h im=%h ovf=%b rdy=%b want 0/0/0/0/1",
               out_valid, m_re, m_im, ovf, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    op_t         dv [8];
    logic [32:0] ex [8];
    int          lat;
    dv[0] = {16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0};
    ex[0] = {1'b0, 16'h4000, 16'h0000};
    dv[1] = {16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1};
    ex[1] = {1'b0, 16'h4000, 16'h0000};
    dv[2] = {16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0};
`ifdef CMULT_PIPE_SAT_EN
    ex[2] = {1'b1, 16'h7FFF, 16'h0000};
`else
    ex[2] = {1'b0, 16'h8000, 16'h0000};
`endif
    dv[3] = {16'h2000, 16'h0000, 16'h2000, 16'h2000, 1'b0};
    ex[3] = {1'b0, 16'h0800, 16'h0800};
    dv[4] = {16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0};
    ex[4] = {1'b0, 16'h0001, 16'h0000};
    dv[5] = {16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0};
    ex[5] = {1'b0, 16'h0000, 16'h0000};
    dv[6] = {16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b1};
    ex[6] = {1'b0, 16'h0000, 16'hE000};
    dv[7] = {16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0};
    ex[7] = {1'b0, 16'h0000, 16'h2000};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(dv[i], 1'b1);
      out_ready = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 8);
      vectors++;
      if (lat != 3) begin
        miscompares++;
        $display("FAIL latency[%0d]: got %0d want 3", i, lat);
      end
      vectors++;
      if ({ovf, m_re, m_im} !== ex[i]) begin
        miscompares++;
        $display("FAIL vector[%0d]: got %h want %h",
                 i, {ovf, m_re, m_im}, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t         ops [8];
    logic [32:0] ex [8];
    int idx, oidx, cyc, stall;
    logic seen, extra;
    for (int i = 0; i < 8; i++) begin
      ops[i].ar = 16'(16'h1000 * (i + 1));
      ops[i].ai = 16'(16'h0800 * (7 - i));
      ops[i].br = 16'(16'h3000 - 16'h0400 * i);
      ops[i].bi = 16'(16'hF000 + 16'h0300 * i);
      ops[i].cj = 1'(i % 2);
      ex[i] = model(ops[i]);
    end
    idx = 0; oidx = 0; cyc = 0; stall = 0; seen = 1'b0;
    while (oidx < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 4;
      end
      out_ready = (stall == 0);
      if (idx < 8) drive(ops[idx], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (stall > 0) begin
        vectors++;
        if (in_ready !== 1'b0 || {ovf, m_re, m_im} !== ex[0]) begin
          miscompares++;
          $display("FAIL stall_hold: got rdy=%b data=%h want rdy=0 data=%h",
                   in_ready, {ovf, m_re, m_im}, ex[0]);
        end
        stall--;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if ({ovf, m_re, m_im} !== ex[oidx]) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got %h want %h",
                   oidx, {ovf, m_re, m_im}, ex[oidx]);
        end
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    vectors++;
    if (oidx != 8) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results want 8", oidx);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) extra = 1'b1;
    end
    vectors++;
    if (extra) begin
      miscompares++;
      $display("FAIL b2b_dup: got extra out_valid want none");
    end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] exp_v, prev;
    op_t  cur;
    int   sent, got, cyc;
    logic pv_stall;
    sent = 0; got = 0; cyc = 0;
    pv_stall = 1'b0; prev = '0;
    cur = rnd_op();
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pv_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || {ovf, m_re, m_im} !== prev) begin
          miscompares++;
          $display("FAIL rnd_hold: got v=%b %h want v=1 %h",
                   out_valid, {ovf, m_re, m_im}, prev);
        end
      end
      drive(cur, (sent < 1000) && ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_extra: got %h want no result",
                   {ovf, m_re, m_im});
        end else begin
          exp_v = q.pop_front();
          if ({ovf, m_re, m_im} !== exp_v) begin
            miscompares++;
            $display("FAIL rnd[%0d]: got %h want %h",
                     got, {ovf, m_re, m_im}, exp_v);
          end
          got++;
        end
      end
      pv_stall = out_valid && !out_ready;
      prev     = {ovf, m_re, m_im};
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        sent++;
        cur = rnd_op();
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 1000) begin
      miscompares++;
      $display("FAIL rnd_count: got %0d want 1000", got);
    end
  endtask

  task automatic test_reset_midflight();
    op_t  o;
    logic stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = {16'(16'h1000 + i), 16'h2000, 16'h3000, 16'h0400, 1'b0};
      drive(o, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_pre: got out_valid=%b want 1", out_valid);
    end
    rst_n     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, m_re, m_im, ovf} !== 34'b0
        || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_rst: got v=%b re=%h im=%h ovf=%b rdy=%b want 0/0/0/0/1",
               out_valid, m_re, m_im, ovf, in_ready);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    vectors++;
    if (stale) begin
      miscompares++;
      $display("FAIL midflight_stale: got stale result want none");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
